// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and default widths.
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RD   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  // Requester port 0 (processor) and port 1 (DMA / I/O engine)
  logic          i_req0;
  logic          i_we0;
  logic [AW-1:0] i_addr0;
  logic [DW-1:0] i_wdata0;
  logic          o_gnt0;
  logic          o_rvalid0;
  logic [DW-1:0] o_rdata0;

  logic          i_req1;
  logic          i_we1;
  logic [AW-1:0] i_addr1;
  logic [DW-1:0] i_wdata1;
  logic          o_gnt1;
  logic          o_rvalid1;
  logic [DW-1:0] o_rdata1;

  // Memory side
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_we;
  logic [DW-1:0] i_mem_rdata;

  modport slave (
    input  i_req0, i_we0, i_addr0, i_wdata0,
    input  i_req1, i_we1, i_addr1, i_wdata1,
    input  i_mem_rdata,
    output o_gnt0, o_rvalid0, o_rdata0,
    output o_gnt1, o_rvalid1, o_rdata1,
    output o_mem_addr, o_mem_wdata, o_mem_we
  );

  modport master (
    output i_req0, i_we0, i_addr0, i_wdata0,
    output i_req1, i_we1, i_addr1, i_wdata1,
    output i_mem_rdata,
    input  o_gnt0, o_rvalid0, o_rdata0,
    input  o_gnt1, o_rvalid1, o_rdata1,
    input  o_mem_addr, o_mem_wdata, o_mem_we
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way picker: a lone request wins outright; ties go to port 0 when
// fixed priority is selected, otherwise to the port that did not own the last access.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_fixed,
  output logic       o_win,
  output logic       o_any
);

  always_comb begin
    o_any = |i_req;
    o_win = 1'b0;
    case (i_req)
      2'b01:   o_win = 1'b0;
      2'b10:   o_win = 1'b1;
      2'b11:   o_win = i_fixed ? 1'b0 : ~i_last;
      default: o_win = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory with 1-cycle read latency.
// One access at a time: IDLE -> ACC -> (RD for reads) -> IDLE, all outputs registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mem_arbiter_if.slave   bus
);

  localparam logic FIXED_PRIO = (PRIO_FIXED != 0);

  arb_state_t    r_state;
  logic          r_owner;
  logic          r_last;
  logic          r_we;
  logic [1:0]    r_gnt;
  logic [1:0]    r_rvalid;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_we;
  logic [DW-1:0] r_rdata;

  logic [1:0]    w_req;
  logic          w_win;
  logic          w_any;

  assign w_req = {bus.i_req1, bus.i_req0};

  rr_pick2 u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .i_fixed (FIXED_PRIO),
    .o_win   (w_win),
    .o_any   (w_any)
  );

  // The memory bus registers double as the capture registers: loading them on the
  // IDLE->ACC edge presents the access to the memory for exactly the ACC cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_we        <= 1'b0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state        <= ST_ACC;
            r_owner        <= w_win;
            r_last         <= w_win;
            r_gnt[w_win]   <= 1'b1;
            r_we           <= w_win ? bus.i_we1 : bus.i_we0;
            r_mem_we       <= w_win ? bus.i_we1 : bus.i_we0;
            r_mem_addr     <= w_win ? bus.i_addr1 : bus.i_addr0;
            r_mem_wdata    <= w_win ? bus.i_wdata1 : bus.i_wdata0;
          end
        end
        ST_ACC: begin
          r_state <= r_we ? ST_IDLE : ST_RD;
        end
        ST_RD: begin
          r_rdata           <= bus.i_mem_rdata;
          r_rvalid[r_owner] <= 1'b1;
          r_state           <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_gnt0      = r_gnt[0];
  assign bus.o_gnt1      = r_gnt[1];
  assign bus.o_rvalid0   = r_rvalid[0];
  assign bus.o_rvalid1   = r_rvalid[1];
  assign bus.o_rdata0    = r_rdata;
  assign bus.o_rdata1    = r_rdata;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_wdata = r_mem_wdata;
  assign bus.o_mem_we    = r_mem_we;

  a_gnt_excl: assert property (@(posedge i_clk) disable iff (i_rst) !(&r_gnt));
  a_rvalid_excl: assert property (@(posedge i_clk) disable iff (i_rst) !(&r_rvalid));
  a_we_in_acc: assert property (@(posedge i_clk) disable iff (i_rst)
    r_mem_we |-> (r_state == ST_ACC));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, read-data scoreboard, corner sequences.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int NV = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus  ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) busf ();

  mem_arbiter #(.AW(AW), .DW(DW), .PRIO_FIXED(0)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .PRIO_FIXED(1)) u_dut_fx (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (busf)
  );

  // Synchronous single-port memory models, 1-cycle read latency
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
    bus.i_mem_rdata <= mem[bus.o_mem_addr];
  end
  always @(posedge clk) busf.i_mem_rdata <= ~busf.o_mem_addr;

  int checks   = 0;
  int failures = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [15:0] a, input logic [15:0] d);
    if (port) begin
      bus.i_req1 = req; bus.i_we1 = we; bus.i_addr1 = a; bus.i_wdata1 = d;
    end else begin
      bus.i_req0 = req; bus.i_we0 = we; bus.i_addr0 = a; bus.i_wdata0 = d;
    end
  endtask

  // Entered #1 after a posedge with the arbiter idle; returns #1 after the posedge
  // where the arbiter is idle again.
  task automatic issue(input bit port, input bit we, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp);
    drive(port, 1'b1, we, a, d);
    @(posedge clk); #1;
    chk("gnt_own",   32'(port ? bus.o_gnt1 : bus.o_gnt0), 1);
    chk("gnt_other", 32'(port ? bus.o_gnt0 : bus.o_gnt1), 0);
    chk("mem_we",    32'(bus.o_mem_we), 32'(we));
    chk("mem_addr",  32'(bus.o_mem_addr), 32'(a));
    if (we) chk("mem_wdata", 32'(bus.o_mem_wdata), 32'(d));
    drive(port, 1'b0, 1'b0, 16'h0, 16'h0);
    if (!we) begin
      if (port) q1.push_back(exp);
      else      q0.push_back(exp);
    end
    @(posedge clk); #1;
    chk("mem_we_off", 32'(bus.o_mem_we), 0);
    if (!we) begin
      @(posedge clk); #1;
      chk("rvalid_t3", 32'(port ? bus.o_rvalid1 : bus.o_rvalid0), 1);
    end
  endtask

  // Scoreboard / protocol monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (bus.o_gnt0 || bus.o_gnt1)
      chk("gnt_overlap", 32'(bus.o_gnt0 & bus.o_gnt1), 0);
    if (bus.o_rvalid0 || bus.o_rvalid1)
      chk("rvalid_overlap", 32'(bus.o_rvalid0 & bus.o_rvalid1), 0);
    if (bus.o_rvalid0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid0_unexpected actual=1 required=0 (t=%0t)", $time);
      end else chk("rdata0", 32'(bus.o_rdata0), 32'(q0.pop_front()));
    end
    if (bus.o_rvalid1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid1_unexpected actual=1 required=0 (t=%0t)", $time);
      end else chk("rdata1", 32'(bus.o_rdata1), 32'(q1.pop_front()));
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vt[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vt[2]  = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
    vt[3]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
    vt[4]  = '{1'b0, 1'b1, 16'h0100, 16'hA000, 16'h0000};
    vt[5]  = '{1'b0, 1'b1, 16'h0101, 16'hA001, 16'h0000};
    vt[6]  = '{1'b0, 1'b1, 16'h0102, 16'hA002, 16'h0000};
    vt[7]  = '{1'b0, 1'b1, 16'h0103, 16'hA003, 16'h0000};
    vt[8]  = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'hA000};
    vt[9]  = '{1'b0, 1'b0, 16'h0101, 16'h0000, 16'hA001};
    vt[10] = '{1'b0, 1'b0, 16'h0102, 16'h0000, 16'hA002};
    vt[11] = '{1'b0, 1'b0, 16'h0103, 16'h0000, 16'hA003};
    vt[12] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};
    vt[13] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF};
    vt[14] = '{1'b0, 1'b1, 16'h0000, 16'h5A5A, 16'h0000};
    vt[15] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h5A5A};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    busf.i_req0 = 1'b0; busf.i_we0 = 1'b0; busf.i_addr0 = '0; busf.i_wdata0 = '0;
    busf.i_req1 = 1'b0; busf.i_we1 = 1'b0; busf.i_addr1 = '0; busf.i_wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0",    32'(bus.o_gnt0), 0);
    chk("rst_gnt1",    32'(bus.o_gnt1), 0);
    chk("rst_rvalid0", 32'(bus.o_rvalid0), 0);
    chk("rst_rvalid1", 32'(bus.o_rvalid1), 0);
    chk("rst_mem_we",  32'(bus.o_mem_we), 0);
    chk("rst_mem_addr",  32'(bus.o_mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.o_mem_wdata), 0);
    chk("rst_rdata",   32'(bus.o_rdata0), 0);
    rst = 1'b0;

    // Single accesses, write/read-back, back-to-back bursts, address extremes
    for (int i = 0; i < NV; i++)
      issue(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata);

    // Contention: both ports held on reads; round-robin alternates, fixed favours port 0
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
    busf.i_req0 = 1'b1; busf.i_addr0 = 16'h0300;
    busf.i_req1 = 1'b1; busf.i_addr1 = 16'h0400;
    q0.push_back(16'hA000); q0.push_back(16'hA000);
    q1.push_back(16'h1234); q1.push_back(16'h1234);
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : 3) @(posedge clk);
      #1;
      chk("rr_gnt0", 32'(bus.o_gnt0), 32'((k % 2) == 0));
      chk("rr_gnt1", 32'(bus.o_gnt1), 32'((k % 2) == 1));
      chk("fx_gnt0", 32'(busf.o_gnt0), 1);
      chk("fx_gnt1", 32'(busf.o_gnt1), 0);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    busf.i_req0 = 1'b0; busf.i_req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while the read is in RD: no rvalid, outputs return to reset values
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(posedge clk); #1;
    chk("mid_gnt0", 32'(bus.o_gnt0), 1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rvalid0",   32'(bus.o_rvalid0), 0);
    chk("mid_mem_addr",  32'(bus.o_mem_addr), 0);
    chk("mid_mem_wdata", 32'(bus.o_mem_wdata), 0);
    chk("mid_rdata",     32'(bus.o_rdata0), 0);
    chk("mid_gnt0_off",  32'(bus.o_gnt0), 0);
    rst = 1'b0;
    issue(1'b0, 1'b0, 16'h0010, 16'h0, 16'hBEEF);

    // req1 pulsed while busy is ignored; req0 dropped after gnt still completes
    drive(1'b0, 1'b1, 1'b0, 16'h0101, 16'h0);
    @(posedge clk); #1;
    chk("late_gnt0", 32'(bus.o_gnt0), 1);
    q0.push_back(16'hA001);
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("late_rvalid0", 32'(bus.o_rvalid0), 1);
    chk("abandon_gnt1_a", 32'(bus.o_gnt1), 0);
    @(posedge clk); #1;
    chk("abandon_gnt1_b", 32'(bus.o_gnt1), 0);
    chk("abandon_gnt0",   32'(bus.o_gnt0), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty0", 32'(q0.size()), 0);
    chk("sb_empty1", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
